// File: rtl/tt_trace_pkg.sv
// Shared types for the trigger-armed trace buffer.
package tt_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_t;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_ALL = 2'b01;
  localparam logic [1:0] MODE_CHG = 2'b10;

endpackage

// File: rtl/tt_trace_fifo.sv
// First-word fall-through FIFO with flush; storage clears on reset.
module tt_trace_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic                       rvalid,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign rvalid = (cnt != '0);
  assign rdata  = mem[rd_ptr];
  assign count  = cnt;

endmodule

// File: rtl/tt_trace_buffer.sv
// Trigger-armed logic-analyser capture: FSM, timestamp,
// change detection and overflow around a trace FIFO.
module tt_trace_buffer
  import tt_trace_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [1:0]             mode,
  input  logic [DATA_W-1:0]      din,
  input  logic                   arm,
  input  logic                   trig,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [TS_W-1:0]        rd_ts,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [1:0]             state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = DATA_W + TS_W;

  trace_state_t      state_q;
  trace_state_t      state_d;
  logic [TS_W-1:0]   ts_q;
  logic [DATA_W-1:0] last_q;
  logic              ovf_q;

  logic              arm_go;
  logic              trig_go;
  logic              cap_cyc;
  logic              qualify;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [TS_W-1:0]   sample_ts;
  logic [W-1:0]      head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm_go)  state_d = ARMED;
      ARMED:   if (trig_go) state_d = CAPTURE;
      CAPTURE: if (drop)    state_d = DONE;
      DONE:    if (arm_go)  state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arm_go  = 1'b0;
    trig_go = 1'b0;
    cap_cyc = 1'b0;
    unique case (1'b1)
      (state_q == IDLE),
      (state_q == DONE):    arm_go  = ena && arm;
      (state_q == ARMED):   trig_go = ena && trig;
      (state_q == CAPTURE): cap_cyc = ena;
      default: ;
    endcase
    cap_cyc = cap_cyc || trig_go;
  end

  // The trigger cycle is sampled with timestamp 0 and always
  // counts as a change, so on-change capture records the start.
  assign sample_ts = trig_go ? '0 : ts_q;
  assign qualify   = cap_cyc &&
                     ((mode == MODE_ALL) ||
                      ((mode == MODE_CHG) &&
                       (trig_go || (din != last_q))));
  assign full      = (count == CW'(DEPTH));
  assign pop       = rd_valid && rd_ready && !arm_go;
  assign push      = qualify && (!full || pop);
  assign drop      = qualify && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
    end else if (arm_go) begin
      ts_q <= '0;
    end else if (trig_go) begin
      ts_q <= TS_W'(1);
    end else if (ena && (state_q == CAPTURE) && (ts_q != '1)) begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (push) begin
      last_q <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (arm_go) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  tt_trace_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (arm_go),
    .push   (push),
    .pop    (pop),
    .wdata  ({din, sample_ts}),
    .rvalid (rd_valid),
    .rdata  (head),
    .count  (count)
  );

  assign rd_data  = head[W-1:TS_W];
  assign rd_ts    = head[TS_W-1:0];
  assign overflow = ovf_q;
  assign state    = state_q;

endmodule

// File: tb/tb_tt_trace_buffer.sv
// Scoreboard bench for tt_trace_buffer across three
// parameter sets sharing one stimulus bus.
module tb_tt_trace_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] din = 8'h00;
  logic       arm = 1'b0;
  logic       trig = 1'b0;
  logic       rd_ready = 1'b0;

  always #5 clk = ~clk;

  logic       a_valid, b_valid, c_valid;
  logic [7:0] a_data, b_data, c_data;
  logic [7:0] a_ts, b_ts;
  logic [2:0] c_ts;
  logic [4:0] a_count;
  logic [2:0] b_count, c_count;
  logic       a_ovf, b_ovf, c_ovf;
  logic [1:0] a_state, b_state, c_state;

  tt_trace_buffer #(.DATA_W(8), .DEPTH(16), .TS_W(8)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .din(din),
    .arm(arm), .trig(trig), .rd_ready(rd_ready),
    .rd_valid(a_valid), .rd_data(a_data), .rd_ts(a_ts),
    .count(a_count), .overflow(a_ovf), .state(a_state)
  );

  tt_trace_buffer #(.DATA_W(8), .DEPTH(4), .TS_W(8)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .din(din),
    .arm(arm), .trig(trig), .rd_ready(rd_ready),
    .rd_valid(b_valid), .rd_data(b_data), .rd_ts(b_ts),
    .count(b_count), .overflow(b_ovf), .state(b_state)
  );

  tt_trace_buffer #(.DATA_W(8), .DEPTH(4), .TS_W(3)) dut_c (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .din(din),
    .arm(arm), .trig(trig), .rd_ready(rd_ready),
    .rd_valid(c_valid), .rd_data(c_data), .rd_ts(c_ts),
    .count(c_count), .overflow(c_ovf), .state(c_state)
  );

  int         sel = 0;
  logic       m_valid, m_ovf;
  logic [7:0] m_data, m_ts;
  logic [4:0] m_count;
  logic [1:0] m_state;

  always_comb begin
    m_valid = a_valid;
    m_data  = a_data;
    m_ts    = a_ts;
    m_count = a_count;
    m_ovf   = a_ovf;
    m_state = a_state;
    if (sel == 1) begin
      m_valid = b_valid;
      m_data  = b_data;
      m_ts    = b_ts;
      m_count = {2'b00, b_count};
      m_ovf   = b_ovf;
      m_state = b_state;
    end else if (sel == 2) begin
      m_valid = c_valid;
      m_data  = c_data;
      m_ts    = {5'b00000, c_ts};
      m_count = {2'b00, c_count};
      m_ovf   = c_ovf;
      m_state = c_state;
    end
  end

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic expect_e(input int d, input int t);
    exp_q.push_back({d[7:0], t[7:0]});
  endtask

  // Monitor: every accepted read is compared against the queue.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && m_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got data 0x%0h ts %0d expected none",
                 m_data, m_ts);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", int'(m_data), int'(e[15:8]));
        check("pop_ts", int'(m_ts), int'(e[7:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arm = 1'b0; trig = 1'b0; mode = 2'b00;
    rd_ready = 1'b0; din = 8'h00;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic arm_it();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    check("armed_state", int'(m_state), 1);
  endtask

  task automatic drain();
    int k = 0;
    rd_ready = 1'b1;
    while (m_valid && k < 64) begin
      cyc();
      k++;
    end
    rd_ready = 1'b0;
    check("drain_empty", int'(m_valid), 0);
  endtask

  task automatic pop_n(input int n);
    rd_ready = 1'b1;
    repeat (n) cyc();
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0] chg_seq [6] = '{8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'h00};

  initial begin
    ena = 1'b1;
    repeat (2) cyc();
    check("rst_state", int'(m_state), 0);
    check("rst_count", int'(m_count), 0);
    check("rst_valid", int'(m_valid), 0);
    check("rst_ovf", int'(m_ovf), 0);
    check("rst_data", int'(m_data), 0);
    check("rst_ts", int'(m_ts), 0);
    rst = 1'b0;

    // Every-cycle capture
    mode = 2'b01;
    arm_it();
    for (int i = 0; i < 4; i++) begin
      din  = 8'(8'h10 + i);
      trig = (i == 0);
      expect_e(16 + i, i);
      cyc();
    end
    trig = 1'b0;
    mode = 2'b00;
    check("all_count", int'(m_count), 4);
    check("all_state", int'(m_state), 2);
    drain();

    // On-change capture
    do_reset();
    mode = 2'b10;
    arm_it();
    for (int i = 0; i < 6; i++) begin
      din  = chg_seq[i];
      trig = (i == 0);
      cyc();
    end
    trig = 1'b0;
    mode = 2'b00;
    expect_e(8'hA5, 0);
    expect_e(8'h3C, 3);
    expect_e(8'h00, 5);
    check("chg_count", int'(m_count), 3);
    drain();

    // Asynchronous reset mid-capture with 5 entries
    do_reset();
    mode = 2'b01;
    arm_it();
    for (int i = 0; i < 5; i++) begin
      din  = 8'(8'h40 + i);
      trig = (i == 0);
      cyc();
    end
    trig = 1'b0;
    mode = 2'b00;
    check("pre_rst_count", int'(m_count), 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_state", int'(m_state), 0);
    check("arst_count", int'(m_count), 0);
    check("arst_valid", int'(m_valid), 0);
    check("arst_ovf", int'(m_ovf), 0);
    check("arst_data", int'(m_data), 0);
    cyc();
    rst = 1'b0;

    // Overflow on a 4-deep FIFO
    sel = 1;
    do_reset();
    mode = 2'b01;
    arm_it();
    for (int i = 0; i < 6; i++) begin
      din  = 8'(8'h20 + i);
      trig = (i == 0);
      cyc();
      if (i == 3) begin
        check("ovf4_count", int'(m_count), 4);
        check("ovf4_flag", int'(m_ovf), 0);
        check("ovf4_state", int'(m_state), 2);
      end
      if (i == 4) begin
        check("ovf5_count", int'(m_count), 4);
        check("ovf5_flag", int'(m_ovf), 1);
        check("ovf5_state", int'(m_state), 3);
      end
    end
    trig = 1'b0;
    mode = 2'b00;
    check("ovf6_count", int'(m_count), 4);
    for (int i = 0; i < 4; i++) expect_e(32 + i, i);
    drain();
    check("ovf_sticky", int'(m_ovf), 1);
    check("ovf_done", int'(m_state), 3);

    // Streaming with simultaneous push and pop
    do_reset();
    mode = 2'b01;
    arm_it();
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din  = 8'(i);
      trig = (i == 0);
      expect_e(i, i);
      cyc();
      check("stream_count_le1", int'(m_count <= 5'd1), 1);
      check("stream_ovf", int'(m_ovf), 0);
    end
    trig = 1'b0;
    mode = 2'b00;
    drain();

    // Timestamp saturation (TS_W=3) then re-arm from DONE
    sel = 2;
    do_reset();
    mode = 2'b10;
    arm_it();
    for (int t = 0; t < 15; t++) begin
      if (t < 2)        din = 8'h00;
      else if (t < 12)  din = 8'h55;
      else if (t == 12) din = 8'hAA;
      else if (t == 13) din = 8'h01;
      else              din = 8'h02;
      trig = (t == 0);
      cyc();
    end
    trig = 1'b0;
    mode = 2'b00;
    check("sat_state", int'(m_state), 3);
    check("sat_ovf", int'(m_ovf), 1);
    check("sat_count", int'(m_count), 4);
    expect_e(8'h00, 0);
    expect_e(8'h55, 2);
    expect_e(8'hAA, 7);
    pop_n(3);
    check("sat_left", int'(m_count), 1);
    check("sat_head_ts", int'(m_ts), 7);
    arm  = 1'b1;
    trig = 1'b1;
    cyc();
    arm  = 1'b0;
    trig = 1'b0;
    check("rearm_state", int'(m_state), 1);
    check("rearm_count", int'(m_count), 0);
    check("rearm_valid", int'(m_valid), 0);
    check("rearm_ovf", int'(m_ovf), 0);
    cyc();
    check("rearm_hold", int'(m_state), 1);

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_trace_buffer.md
# tt_trace_buffer

Parametrised trigger-armed capture buffer for Tiny Tapeout user designs. It samples an N-bit design bus, such as `uo_out`, after a trigger, stores each sample with a timestamp in a FIFO, and drains it over a ready/valid read port. It generalises the fixed 8-bit pin-level harness into a reusable on-chip logic-analyser block. The block is instantiated beside the user core inside a `tt_um_*` top, or inside a bench.

## Interface
Parameters:
- `DATA_W`, 8: width of the sampled bus (1..32).
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `TS_W`, 8: timestamp width; the timestamp saturates at all-ones.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst`, in, 1: asynchronous, active-high reset.
- `ena`, in, 1: global enable. While low, no sampling occurs, the timestamp holds and the state holds. Reads still work.
- `mode`, in, 2: sampling mode. 00 = off, 01 = every cycle, 10 = on change.
- `din`, in, `DATA_W`: the bus being sampled.
- `arm`, in, 1: single-cycle arm request.
- `trig`, in, 1: trigger.
- `rd_ready`, in, 1: consumer ready to accept a read.
- `rd_valid`, out, 1: FIFO is non-empty (first-word fall-through).
- `rd_data`, out, `DATA_W`: head entry data.
- `rd_ts`, out, `TS_W`: head entry timestamp.
- `count`, out, `$clog2(DEPTH)+1`: current number of FIFO entries.
- `overflow`, out, 1: sticky flag; a qualifying sample was dropped.
- `state`, out, 2: current state. IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

## Operation
- **IDLE**
  - `arm` moves the block to ARMED.
  - On arm, the FIFO is flushed (pointers and `count` set to 0) and `overflow` is cleared.
- **ARMED**
  - `trig` (with `ena` high) moves the block to CAPTURE.
  - The trigger cycle itself is a sample cycle and uses timestamp 0.
  - `arm` is ignored.
- **CAPTURE**
  - The timestamp counter starts at 0 on the trigger cycle and increments by 1 each `ena` cycle.
  - It saturates at 2^TS_W−1.
  - A cycle *qualifies* when either:
    - mode is 01, or
    - mode is 10 and (`din` differs from the last stored value, or it is the trigger cycle).
  - Mode 00 never qualifies; mode 11 is treated as 00.
  - A qualifying cycle pushes {`din`, ts} into the FIFO and updates the last-stored-value register.
- **Full FIFO**
  - If a qualifying cycle occurs while `count==DEPTH` and no pop happens that cycle:
    - the sample is dropped,
    - `overflow` is set,
    - the block moves to DONE.
  - A simultaneous pop frees a slot, so the push proceeds; this allows streaming capture.
- **DONE**
  - No sampling.
  - `arm` moves the block to ARMED and flushes the FIFO; a pop in the same cycle is ignored.
  - `arm` while in CAPTURE is ignored.
- **Read**
  - A pop occurs when `rd_valid && rd_ready`; it is legal in every state.
  - `rd_data` and `rd_ts` present the head entry combinationally from storage.
- **Simultaneous events**
  - Push and pop in the same cycle leave `count` unchanged.
  - `arm` and `trig` in the same cycle from IDLE or DONE: `trig` is ignored, because arm takes effect first.
- **Pointers**: `$clog2(DEPTH)` bits wide and wrap modulo DEPTH.

## Timing
- Reset values:
  - state IDLE
  - `count` 0, `rd_valid` 0, `overflow` 0
  - `rd_data` and `rd_ts` 0 (storage cleared)
  - timestamp 0, last-stored value 0
- Reset mid-capture aborts immediately and discards all entries.
- Capture latency: a sample is taken at edge *k*; `rd_valid` and `count` reflect it after edge *k*, i.e. visible in cycle *k+1*.
- State changes are registered: `trig` sampled at edge *k* gives `state==CAPTURE` after edge *k*.
- Pop: the head advances at the edge where `rd_valid && rd_ready`. Zero-bubble back-to-back reads are supported.
- `overflow` and the DONE transition take effect at the same edge as the dropped sample.

## Structure
- Package `tt_trace_pkg` holds:
  - the state enum `trace_state_t` (IDLE, ARMED, CAPTURE, DONE),
  - the mode constants `MODE_OFF`, `MODE_ALL`, `MODE_CHG`.
- Sub-module `tt_trace_fifo` (parameters `W = DATA_W+TS_W`, `DEPTH`):
  - storage array, read/write pointers and `count`,
  - push/pop inputs, first-word fall-through head output.
- The top-level module contains the FSM, the timestamp counter, change detection and the overflow flag.

## Test plan
- **Reset and idle**
  - Stimulus: assert `rst` mid-capture with 5 entries stored.
  - Response: `state`=0, `count`=0, `rd_valid`=0, `overflow`=0 immediately (asynchronously).
- **Every-cycle capture**
  - Stimulus: mode=01, arm, `trig` at cycle 0, `din` = 0x10..0x13 over 4 cycles, `rd_ready`=0.
  - Response: `count`=4; reading yields (0x10,0), (0x11,1), (0x12,2), (0x13,3).
- **On-change capture**
  - Stimulus: mode=10, `din` sequence A5, A5, A5, 3C, 3C, 00 starting at the trigger cycle.
  - Response: 3 entries, (A5,0), (3C,3), (00,5).
- **Overflow**
  - Stimulus: DEPTH=4, mode=01, `rd_ready`=0, 6 cycles of capture.
  - Response: `count`=4 and `overflow`=1 after the 5th sample; `state`=DONE; entries hold the first 4 samples.
- **Streaming with simultaneous push and pop**
  - Stimulus: DEPTH=4, mode=01, `rd_ready`=1 throughout, 20 cycles.
  - Response: `count` stays ≤1, `overflow`=0, 20 entries read with timestamps 0..19.
- **Timestamp saturation and re-arm**
  - Stimulus: TS_W=3, mode=10, changes at ts 2 and 12; then `arm` in DONE together with `trig`.
  - Response: timestamps read as 2 and 7; after re-arm the FIFO is flushed, `trig` in the arm cycle is ignored, and `state`=ARMED.
